// File: rtl/axil_order_pkg.sv
// Shared constants and helpers for the AXI-Lite order-stream slave.
package axil_order_pkg;

  // Register map: config registers sit below these two fixed words.
  localparam logic [7:0] ORDER_ADDR  = 8'h48;
  localparam logic [7:0] STATUS_ADDR = 8'h4C;

  // AXI response codes used by this slave.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // STATUS word layout.
  localparam int STATUS_NOT_FULL_BIT = 0;
  localparam int STATUS_EMPTY_BIT    = 1;
  localparam int STATUS_COUNT_LSB    = 8;
  localparam int STATUS_COUNT_W      = 8;

  // Merge new_v into old_v one byte lane at a time, as selected by strb.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/order_fifo.sv
// Synchronous order FIFO; a pop on a full FIFO frees the slot for a push in the same cycle.
module order_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en;
  logic             pop_en;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  // Qualify push/pop, advance wrapping pointers and track occupancy.
  always_comb begin
    pop_en   = pop && !empty;
    push_en  = push && (!full || pop_en);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers; reset flushes the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/axil_order_slave.sv
// AXI4-Lite slave: byte-enabled config registers, an order push port backed by a FIFO, and a status word.
module axil_order_slave
  import axil_order_pkg::*;
#(
  parameter int AXIL_DATA_WIDTH  = 32,
  parameter int AXIL_ADDR_WIDTH  = 8,
  parameter int NUM_CFG_REGS     = 18,
  parameter int ORDER_FIFO_DEPTH = 16
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [AXIL_ADDR_WIDTH-1:0]        s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [AXIL_DATA_WIDTH-1:0]        s00_axi_wdata,
  input  logic [AXIL_DATA_WIDTH/8-1:0]      s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [AXIL_ADDR_WIDTH-1:0]        s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [AXIL_DATA_WIDTH-1:0]        s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic [32*NUM_CFG_REGS-1:0]        cfg_regs,
  output logic [AXIL_DATA_WIDTH-1:0]        order_data,
  output logic                              order_valid,
  input  logic                              order_ready
);

  localparam int WA    = AXIL_ADDR_WIDTH - 2;
  localparam int CNT_W = $clog2(ORDER_FIFO_DEPTH) + 1;
  localparam logic [WA-1:0] ORDER_IDX  = WA'(ORDER_ADDR >> 2);
  localparam logic [WA-1:0] STATUS_IDX = WA'(STATUS_ADDR >> 2);
  localparam logic [WA-1:0] CFG_LIMIT  = WA'(NUM_CFG_REGS);

  logic                       aw_held_q, aw_held_d;
  logic [WA-1:0]              aw_idx_q, aw_idx_d;
  logic                       w_held_q, w_held_d;
  logic [31:0]                w_data_q, w_data_d;
  logic [3:0]                 w_strb_q, w_strb_d;
  logic                       bvalid_q, bvalid_d;
  logic [1:0]                 bresp_q, bresp_d;
  logic                       rvalid_q, rvalid_d;
  logic [31:0]                rdata_q, rdata_d;
  logic [1:0]                 rresp_q, rresp_d;
  logic [31:0]                cfg_q [NUM_CFG_REGS];
  logic [31:0]                cfg_d [NUM_CFG_REGS];

  logic                       aw_fire, w_fire, ar_fire, pop_fire;
  logic [WA-1:0]              wr_idx, rd_idx;
  logic [31:0]                wr_data;
  logic [3:0]                 wr_strb;
  logic                       wr_is_cfg, wr_is_order, commit;
  logic                       fifo_push, fifo_full, fifo_empty;
  logic [CNT_W-1:0]           fifo_count;
  logic [31:0]                status_word;
  logic                       unused_ok;

  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign s00_axi_awready = s00_axi_aresetn && !aw_held_q && !bvalid_q;
  assign s00_axi_wready  = s00_axi_aresetn && !w_held_q && !bvalid_q;
  assign s00_axi_arready = s00_axi_aresetn && !rvalid_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = rresp_q;
  assign order_valid     = !fifo_empty;
  assign pop_fire        = order_ready && !fifo_empty;

  order_fifo #(
    .DEPTH (ORDER_FIFO_DEPTH),
    .WIDTH (AXIL_DATA_WIDTH),
    .CNT_W (CNT_W)
  ) u_order_fifo (
    .clk   (s00_axi_aclk),
    .rst_n (s00_axi_aresetn),
    .push  (fifo_push),
    .pop   (order_ready),
    .din   (wr_data),
    .dout  (order_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Write path: latch AW/W independently, commit once both are present and the FIFO can take an order.
  always_comb begin
    aw_fire     = s00_axi_awvalid && s00_axi_awready;
    w_fire      = s00_axi_wvalid && s00_axi_wready;
    wr_idx      = aw_held_q ? aw_idx_q : s00_axi_awaddr[AXIL_ADDR_WIDTH-1:2];
    wr_data     = w_held_q ? w_data_q : s00_axi_wdata;
    wr_strb     = w_held_q ? w_strb_q : s00_axi_wstrb;
    wr_is_cfg   = (wr_idx < CFG_LIMIT);
    wr_is_order = (wr_idx == ORDER_IDX);
    commit      = (aw_held_q || aw_fire) && (w_held_q || w_fire) && !bvalid_q &&
                  (!wr_is_order || !fifo_full || pop_fire);
    fifo_push   = commit && wr_is_order;

    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    cfg_d     = cfg_q;

    if (aw_fire) begin
      aw_held_d = 1'b1;
      aw_idx_d  = s00_axi_awaddr[AXIL_ADDR_WIDTH-1:2];
    end
    if (w_fire) begin
      w_held_d = 1'b1;
      w_data_d = s00_axi_wdata;
      w_strb_d = s00_axi_wstrb;
    end
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = (wr_is_cfg || wr_is_order) ? RESP_OKAY : RESP_SLVERR;
      if (wr_is_cfg) begin
        for (int i = 0; i < NUM_CFG_REGS; i++) begin
          if (wr_idx == WA'(i)) cfg_d[i] = apply_wstrb(cfg_q[i], wr_data, wr_strb);
        end
      end
    end
    if (bvalid_q && s00_axi_bready) begin
      bvalid_d  = 1'b0;
      bresp_d   = RESP_OKAY;
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
  end

  // Read path: decode and register the response in the AR handshake cycle.
  always_comb begin
    ar_fire     = s00_axi_arvalid && s00_axi_arready;
    rd_idx      = s00_axi_araddr[AXIL_ADDR_WIDTH-1:2];
    status_word = '0;
    status_word[STATUS_NOT_FULL_BIT] = !fifo_full;
    status_word[STATUS_EMPTY_BIT]    = fifo_empty;
    status_word[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(fifo_count);
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RESP_OKAY;
      if (rd_idx < CFG_LIMIT) begin
        for (int i = 0; i < NUM_CFG_REGS; i++) begin
          if (rd_idx == WA'(i)) rdata_d = cfg_q[i];
        end
      end else if (rd_idx == STATUS_IDX) begin
        rdata_d = status_word;
      end else if (rd_idx != ORDER_IDX) begin
        rresp_d = RESP_SLVERR;
      end
    end else if (rvalid_q && s00_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  // Flatten the config array onto the output vector.
  always_comb begin
    cfg_regs = '0;
    for (int i = 0; i < NUM_CFG_REGS; i++) cfg_regs[32*i +: 32] = cfg_q[i];
  end

  // State registers; reset drops held AW/W, pending B/R and clears config.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      for (int i = 0; i < NUM_CFG_REGS; i++) cfg_q[i] <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      cfg_q     <= cfg_d;
    end
  end

endmodule

// File: tb/tb_axil_order_slave.sv
// Directed bench for axil_order_slave with a queue/array reference model of the register map and order FIFO.
module tb_axil_order_slave;

   localparam int NCFG  = 18;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [7:0]    awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic          awvalid, wvalid, bready, arvalid, rready, order_ready;
   logic          awready, wready, bvalid, arready, rvalid, order_valid;
   logic [31:0]   wdata, rdata, order_data;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;
   logic [32*NCFG-1:0] cfg_regs;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: config array plus an order queue.
   logic [31:0] m_cfg [NCFG];
   logic [31:0] mq [$];
   bit          pop_now;

   axil_order_slave dut (
      .s00_axi_aclk    (clk),
      .s00_axi_aresetn (rst_n),
      .s00_axi_awaddr  (awaddr),
      .s00_axi_awprot  (awprot),
      .s00_axi_awvalid (awvalid),
      .s00_axi_awready (awready),
      .s00_axi_wdata   (wdata),
      .s00_axi_wstrb   (wstrb),
      .s00_axi_wvalid  (wvalid),
      .s00_axi_wready  (wready),
      .s00_axi_bresp   (bresp),
      .s00_axi_bvalid  (bvalid),
      .s00_axi_bready  (bready),
      .s00_axi_araddr  (araddr),
      .s00_axi_arprot  (arprot),
      .s00_axi_arvalid (arvalid),
      .s00_axi_arready (arready),
      .s00_axi_rdata   (rdata),
      .s00_axi_rresp   (rresp),
      .s00_axi_rvalid  (rvalid),
      .s00_axi_rready  (rready),
      .cfg_regs        (cfg_regs),
      .order_data      (order_data),
      .order_valid     (order_valid),
      .order_ready     (order_ready)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // One comparison: count it, report it when it differs.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Apply a committed write to the model and return the response it must produce.
   function automatic logic [1:0] model_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int idx;
      idx = int'(addr) / 4;
      if (idx < NCFG) begin
         for (int b = 0; b < 4; b++) if (strb[b]) m_cfg[idx][8*b +: 8] = data[8*b +: 8];
         return 2'b00;
      end else if (idx == 18) begin
         mq.push_back(data);
         return 2'b00;
      end
      return 2'b10;
   endfunction

   // Read value and response the model predicts for a given address.
   task automatic model_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
      int idx;
      int n;
      idx  = int'(addr) / 4;
      n    = mq.size();
      data = 32'h0;
      resp = 2'b00;
      if (idx < NCFG) data = m_cfg[idx];
      else if (idx == 19) data = 32'((n < DEPTH) ? 1 : 0) + 32'((n == 0) ? 2 : 0) + 32'(n * 256);
      else if (idx != 18) resp = 2'b10;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCFG; i++) m_cfg[i] = 32'h0;
      mq.delete();
   endtask

   // Model consumer: the head leaves whenever the sequencer is ready and an order is present.
   initial begin
      forever begin
         @(negedge clk); #1;
         pop_now = (mq.size() > 0) && order_ready && rst_n;
         @(posedge clk); #1;
         if (pop_now && rst_n) void'(mq.pop_front());
      end
   end

   // Every cycle: config vector and FIFO head must match the model.
   initial begin
      forever begin
         @(negedge clk); #2;
         for (int i = 0; i < NCFG; i++) checkOutput($sformatf("cfg%0d", i), cfg_regs[32*i +: 32], m_cfg[i]);
         checkOutput("order_valid", 32'(order_valid), 32'(mq.size() != 0));
         if (mq.size() > 0) checkOutput("order_data", order_data, mq[0]);
      end
   end

   // Full AXI write with optional W lead (AW delayed) and B backpressure.
   task automatic axiWrite(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int w_lead, input int b_hold, output logic [1:0] resp_out);
      int cyc, b_seen;
      bit aw_up, aw_done, w_done, b_done;
      logic aw_fire, w_fire;
      logic [1:0] exp_resp;
      cyc = 0; b_seen = 0; aw_done = 0; w_done = 0; b_done = 0;
      exp_resp = 2'b00; resp_out = 2'b11;
      awaddr = addr; wdata = data; wstrb = strb;
      wvalid = 1'b1;
      aw_up = (w_lead == 0);
      awvalid = aw_up;
      bready = (b_hold == 0);
      while (!b_done && cyc < 60) begin
         @(negedge clk);
         aw_fire = awvalid && awready;
         w_fire  = wvalid && wready;
         if (b_seen == 0) begin
            if (bvalid) begin
               checkOutput("b_after_aw_w", 32'({aw_done, w_done}), 32'h3);
               exp_resp = model_write(addr, data, strb);
               checkOutput("bresp", 32'(bresp), 32'(exp_resp));
               resp_out = bresp;
               b_seen = 1;
            end
         end else begin
            checkOutput("bvalid_held", 32'(bvalid), 32'h1);
            checkOutput("awready_blocked", 32'(awready), 32'h0);
            checkOutput("wready_blocked", 32'(wready), 32'h0);
            checkOutput("bresp_held", 32'(bresp), 32'(exp_resp));
            b_seen++;
         end
         if (b_seen > 0 && bready) b_done = 1;
         @(posedge clk); #1;
         if (aw_fire) begin awvalid = 1'b0; aw_done = 1; end
         if (w_fire)  begin wvalid = 1'b0;  w_done = 1; end
         cyc++;
         if (!aw_up && cyc >= w_lead) begin awvalid = 1'b1; aw_up = 1; end
         if (b_seen >= b_hold) bready = 1'b1;
      end
      if (!b_done) checkOutput("write_timeout", 32'h0, 32'h1);
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
      @(negedge clk);
      checkOutput("bvalid_single", 32'(bvalid), 32'h0);
      @(posedge clk); #1;
   endtask

   // Full AXI read with optional R backpressure; expectation taken from the model at the AR handshake.
   task automatic axiRead(input logic [7:0] addr, input int r_hold,
                          output logic [31:0] got, output logic [1:0] got_resp);
      int cyc, r_seen, fire_cyc;
      bit ar_done, r_done;
      logic ar_fire;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
      cyc = 0; r_seen = 0; fire_cyc = -10; ar_done = 0; r_done = 0;
      exp_data = 32'h0; exp_resp = 2'b00; got = 32'hDEAD_DEAD; got_resp = 2'b11;
      araddr = addr; arvalid = 1'b1; rready = (r_hold == 0);
      while (!r_done && cyc < 60) begin
         @(negedge clk);
         ar_fire = arvalid && arready;
         if (ar_fire) model_read(addr, exp_data, exp_resp);
         if (r_seen == 0) begin
            if (rvalid) begin
               checkOutput("r_latency", 32'(ar_done && cyc == fire_cyc + 1), 32'h1);
               checkOutput("rdata", rdata, exp_data);
               checkOutput("rresp", 32'(rresp), 32'(exp_resp));
               got = rdata; got_resp = rresp;
               r_seen = 1;
            end
         end else begin
            checkOutput("rvalid_held", 32'(rvalid), 32'h1);
            checkOutput("arready_blocked", 32'(arready), 32'h0);
            checkOutput("rdata_held", rdata, exp_data);
            r_seen++;
         end
         if (r_seen > 0 && rready) r_done = 1;
         @(posedge clk); #1;
         if (ar_fire) begin arvalid = 1'b0; ar_done = 1; fire_cyc = cyc; end
         cyc++;
         if (r_seen >= r_hold) rready = 1'b1;
      end
      if (!r_done) checkOutput("read_timeout", 32'h0, 32'h1);
      arvalid = 1'b0; rready = 1'b0;
      @(negedge clk);
      checkOutput("rvalid_single", 32'(rvalid), 32'h0);
      @(posedge clk); #1;
   endtask

   // Directed sequence with hand-computed literals pinning the model.
   task automatic applyStimulus();
      logic [31:0] got;
      logic [1:0]  resp;

      // Byte-enable merge on cfg 0.
      axiWrite(8'h00, 32'h1234_5678, 4'b0011, 0, 0, resp);
      axiWrite(8'h00, 32'hAABB_CCDD, 4'b1100, 0, 0, resp);
      axiRead(8'h00, 0, got, resp);
      checkOutput("cfg0_merge_lit", got, 32'hAABB_5678);
      checkOutput("cfg0_resp_lit", 32'(resp), 32'h0);

      // Last cfg register and a mid-map one.
      axiWrite(8'h44, 32'hDEAD_BEEF, 4'hF, 0, 0, resp);
      axiWrite(8'h10, 32'h0102_0304, 4'b0101, 0, 0, resp);
      axiRead(8'h44, 0, got, resp);
      checkOutput("cfg17_lit", got, 32'hDEAD_BEEF);
      axiRead(8'h10, 0, got, resp);
      checkOutput("cfg4_lit", got, 32'h0002_0004);

      // W three cycles ahead of AW into the order port.
      axiWrite(8'h48, 32'hCAFE_0001, 4'hF, 3, 0, resp);
      @(negedge clk);
      checkOutput("order_valid_lit", 32'(order_valid), 32'h1);
      checkOutput("order_data_lit", order_data, 32'hCAFE_0001);
      @(posedge clk); #1;
      order_ready = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      order_ready = 1'b0;

      // Fill the FIFO, then a 17th push must stall until a single pop.
      for (int k = 0; k < DEPTH; k++) axiWrite(8'h48, 32'h1000_0000 + 32'(k), 4'hF, 0, 0, resp);
      axiRead(8'h4C, 0, got, resp);
      checkOutput("status_full_lit", got, 32'h0000_1000);
      fork
         axiWrite(8'h48, 32'hF000_0011, 4'b0000, 0, 0, resp);
         begin
            repeat (6) begin
               @(negedge clk);
               checkOutput("stall_no_bvalid", 32'(bvalid), 32'h0);
            end
            @(posedge clk); #1;
            order_ready = 1'b1;
            @(posedge clk); #1;
            order_ready = 1'b0;
         end
      join
      axiRead(8'h4C, 0, got, resp);
      checkOutput("status_refill_lit", got, 32'h0000_1000);
      @(negedge clk);
      checkOutput("head_after_pop_lit", order_data, 32'h1000_0001);
      @(posedge clk); #1;

      // Write-only and unmapped addresses.
      axiWrite(8'h4C, 32'hFFFF_FFFF, 4'hF, 0, 0, resp);
      checkOutput("status_wr_slverr_lit", 32'(resp), 32'h2);
      axiWrite(8'h60, 32'hFFFF_FFFF, 4'hF, 0, 0, resp);
      checkOutput("unmapped_wr_slverr_lit", 32'(resp), 32'h2);
      axiRead(8'h60, 0, got, resp);
      checkOutput("unmapped_rd_data_lit", got, 32'h0);
      checkOutput("unmapped_rd_resp_lit", 32'(resp), 32'h2);
      axiRead(8'h48, 0, got, resp);
      checkOutput("order_rd_lit", got, 32'h0);
      checkOutput("order_rd_resp_lit", 32'(resp), 32'h0);

      // B and R backpressure for five cycles.
      axiWrite(8'h08, 32'h5555_AAAA, 4'hF, 0, 5, resp);
      axiRead(8'h08, 5, got, resp);
      checkOutput("cfg2_hold_lit", got, 32'h5555_AAAA);

      // Drain, push three, then reset in the middle of a write.
      order_ready = 1'b1;
      repeat (DEPTH + 4) begin @(posedge clk); #1; end
      order_ready = 1'b0;
      for (int k = 0; k < 3; k++) axiWrite(8'h48, 32'h3000_0000 + 32'(k), 4'hF, 0, 0, resp);
      axiRead(8'h4C, 0, got, resp);
      checkOutput("status_three_lit", got, 32'h0000_0301);
      awaddr = 8'h04; awvalid = 1'b1; wvalid = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      checkOutput("rst_bvalid", 32'(bvalid), 32'h0);
      checkOutput("rst_awready", 32'(awready), 32'h0);
      checkOutput("rst_order_valid", 32'(order_valid), 32'h0);
      awvalid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("post_rst_bvalid", 32'(bvalid), 32'h0);
      for (int i = 0; i < NCFG; i++) checkOutput($sformatf("post_rst_cfg%0d_lit", i), cfg_regs[32*i +: 32], 32'h0);
      @(posedge clk); #1;
      axiRead(8'h4C, 0, got, resp);
      checkOutput("post_rst_status_lit", got, 32'h0000_0003);
   endtask

   // Reset, check idle outputs, run the sequence, report.
   initial begin
      rst_n = 1'b0;
      awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
      awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; order_ready = 0;
      wdata = '0; wstrb = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_bvalid", 32'(bvalid), 32'h0);
      checkOutput("reset_bresp", 32'(bresp), 32'h0);
      checkOutput("reset_rvalid", 32'(rvalid), 32'h0);
      checkOutput("reset_rdata", rdata, 32'h0);
      checkOutput("reset_rresp", 32'(rresp), 32'h0);
      checkOutput("reset_awready", 32'(awready), 32'h0);
      checkOutput("reset_wready", 32'(wready), 32'h0);
      checkOutput("reset_arready", 32'(arready), 32'h0);
      checkOutput("reset_order_valid", 32'(order_valid), 32'h0);
      checkOutput("reset_order_data", order_data, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      applyStimulus();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Absolute time bound in case a handshake never completes.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
